// File: rtl/hazard_forward_unit.sv
// Hazard controller for a 5-stage pipeline: EX operand forwarding selects,
// load-use stall sequencing and branch squash of the wrong-path instructions.
module hazard_forward_unit #(
    parameter int RW       = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rs1D,
    input  logic [RW-1:0] rs2D,
    input  logic          useRs1D,
    input  logic          useRs2D,
    input  logic [RW-1:0] rdD,
    input  logic          regWriteD,
    input  logic          memReadD,
    input  logic          branchTakenE,
    output logic [1:0]    fwdA,
    output logic [1:0]    fwdB,
    output logic          stallF,
    output logic          stallD,
    output logic          flushD,
    output logic          flushE
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic          stall, flush_e, flush_d, bubble;

    // Scoreboard: _p0 is the EX entry, _p1 the MEM entry. The WB entry is the
    // MEM entry one cycle later and no decision ever looks at it, so it is not held.
    logic          vld_p0, wr_p0, ld_p0;
    logic [RW-1:0] rd_p0;
    logic          vld_p1, wr_p1;
    logic [RW-1:0] rd_p1;

    logic          hit_a_p0, hit_b_p0, hit_a_p1, hit_b_p1, load_use;

    function automatic logic producer(input logic use_rs, input logic [RW-1:0] rs,
                                      input logic vld, input logic wr,
                                      input logic [RW-1:0] rd);
        return use_rs && (rs != '0) && vld && wr && (rd == rs);
    endfunction

    // The EX producer is the newest, so it wins over MEM unless its data is a load.
    function automatic logic [1:0] fwd_sel(input logic hit_e, input logic ld_e,
                                           input logic hit_m);
        if (hit_e && !ld_e) return 2'b01;
        if (hit_m)          return 2'b10;
        return 2'b00;
    endfunction

    assign hit_a_p0 = producer(useRs1D, rs1D, vld_p0, wr_p0, rd_p0);
    assign hit_b_p0 = producer(useRs2D, rs2D, vld_p0, wr_p0, rd_p0);
    assign hit_a_p1 = producer(useRs1D, rs1D, vld_p1, wr_p1, rd_p1);
    assign hit_b_p1 = producer(useRs2D, rs2D, vld_p1, wr_p1, rd_p1);
    assign load_use = ld_p0 && (hit_a_p0 || hit_b_p0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        flush_e   = 1'b0;
        flush_d   = 1'b0;
        if (branchTakenE) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        stall   = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                STALL: begin
                    stall   = 1'b1;
                    flush_e = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign bubble = stall | flush_e;

    // Reset forces the controls low at once, whatever the branch input does.
    assign stallF = rst & stall;
    assign stallD = rst & stall;
    assign flushD = rst & flush_d;
    assign flushE = rst & flush_e;

    // Decode -> EX boundary: control state, valid bits and forwarding selects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            cnt    <= 2'd0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            fwdA   <= 2'b00;
            fwdB   <= 2'b00;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            vld_p0 <= !bubble;
            vld_p1 <= vld_p0;
            fwdA   <= bubble ? 2'b00 : fwd_sel(hit_a_p0, ld_p0, hit_a_p1);
            fwdB   <= bubble ? 2'b00 : fwd_sel(hit_b_p0, ld_p0, hit_b_p1);
        end
    end

    // EX -> MEM boundary: entry payload, qualified by the valid bits above
    always_ff @(posedge clk) begin
        rd_p0 <= rdD;
        wr_p0 <= regWriteD;
        ld_p0 <= memReadD;
        rd_p1 <= rd_p0;
        wr_p1 <= wr_p0;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_LAT 1 and 3) share one
// directed instruction stream; a rule-level model is compared every cycle.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rs1D = '0, rs2D = '0, rdD = '0;
    logic       useRs1D = 1'b0, useRs2D = 1'b0, regWriteD = 1'b0;
    logic       memReadD = 1'b0, branchTakenE = 1'b0;

    logic [1:0] fwdA_o [2];
    logic [1:0] fwdB_o [2];
    logic       stallF_o [2];
    logic       stallD_o [2];
    logic       flushD_o [2];
    logic       flushE_o [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.RW(4), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D),
        .useRs2D(useRs2D), .rdD(rdD), .regWriteD(regWriteD), .memReadD(memReadD),
        .branchTakenE(branchTakenE), .fwdA(fwdA_o[0]), .fwdB(fwdB_o[0]),
        .stallF(stallF_o[0]), .stallD(stallD_o[0]), .flushD(flushD_o[0]),
        .flushE(flushE_o[0])
    );

    hazard_forward_unit #(.RW(4), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D),
        .useRs2D(useRs2D), .rdD(rdD), .regWriteD(regWriteD), .memReadD(memReadD),
        .branchTakenE(branchTakenE), .fwdA(fwdA_o[1]), .fwdB(fwdB_o[1]),
        .stallF(stallF_o[1]), .stallD(stallD_o[1]), .flushD(flushD_o[1]),
        .flushE(flushE_o[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic       vld;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
    } ent_t;

    ent_t       m_ex [2];
    ent_t       m_mem [2];
    int         m_left [2];
    logic [1:0] m_fa [2];
    logic [1:0] m_fb [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic writes(input ent_t e, input logic use_rs, input logic [3:0] rs);
        return use_rs && rs != 4'd0 && e.vld && e.wr && e.rd == rs;
    endfunction

    function automatic logic [1:0] operand_src(input ent_t ex, input ent_t mem,
                                               input logic use_rs, input logic [3:0] rs);
        if (writes(ex, use_rs, rs) && !ex.ld) return 2'b01;
        if (writes(mem, use_rs, rs))          return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic st, fe, fd, hz;
            if (!rst) begin
                m_ex[i] = '0; m_mem[i] = '0; m_left[i] = 0; m_fa[i] = 2'b00; m_fb[i] = 2'b00;
                st = 1'b0; fe = 1'b0; fd = 1'b0;
            end else begin
                hz = m_ex[i].ld && (writes(m_ex[i], useRs1D, rs1D) || writes(m_ex[i], useRs2D, rs2D));
                st = 1'b0; fe = 1'b0; fd = 1'b0;
                if (branchTakenE) begin
                    fd = 1'b1; fe = 1'b1;
                end else if (m_left[i] > 0 || hz) begin
                    st = 1'b1; fe = 1'b1;
                end
            end
            chk($sformatf("u%0d.fwdA", i), fwdA_o[i], m_fa[i]);
            chk($sformatf("u%0d.fwdB", i), fwdB_o[i], m_fb[i]);
            chk($sformatf("u%0d.stallF", i), stallF_o[i], st);
            chk($sformatf("u%0d.stallD", i), stallD_o[i], st);
            chk($sformatf("u%0d.flushD", i), flushD_o[i], fd);
            chk($sformatf("u%0d.flushE", i), flushE_o[i], fe);
            if (rst) begin
                if (branchTakenE)      m_left[i] = 0;
                else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
                else if (st)           m_left[i] = lat_of(i) - 1;
                m_fa[i]  = (st || fe) ? 2'b00 : operand_src(m_ex[i], m_mem[i], useRs1D, rs1D);
                m_fb[i]  = (st || fe) ? 2'b00 : operand_src(m_ex[i], m_mem[i], useRs2D, rs2D);
                m_mem[i] = m_ex[i];
                m_ex[i]  = (st || fe) ? '0 : ent_t'{1'b1, rdD, regWriteD, memReadD};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] r1, input logic u1, input logic [3:0] r2,
                        input logic u2, input logic [3:0] rd, input logic wr,
                        input logic ld, input logic br);
        @(posedge clk);
        #1;
        rs1D = r1; useRs1D = u1; rs2D = r2; useRs2D = u2;
        rdD = rd; regWriteD = wr; memReadD = ld; branchTakenE = br;
    endtask

    task automatic nop();
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_both(input string nm, input int sel, input int exp);
        for (int i = 0; i < 2; i++) begin
            int act;
            case (sel)
                0: act = fwdA_o[i];
                1: act = fwdB_o[i];
                2: act = stallD_o[i];
                3: act = stallF_o[i];
                4: act = flushD_o[i];
                default: act = flushE_o[i];
            endcase
            chk($sformatf("%s[u%0d]", nm, i), act, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        for (int s = 0; s < 6; s++) chk_both("reset_out", s, 0);
        @(posedge clk); #1 rst = 1'b1;

        // ADD r3 ; SUB r7 = r3 - r4
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd3, 1'b1, 4'd4, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk_both("addsub_stall", 2, 0);
        nop();
        @(negedge clk); chk_both("addsub_fwdA", 0, 1); chk_both("addsub_fwdB", 1, 0);

        // ADD r3 ; unrelated r9 ; AND r3, r3
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
        step(4'd3, 1'b1, 4'd3, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
        nop();
        @(negedge clk); chk_both("mem_fwdA", 0, 2); chk_both("mem_fwdB", 1, 2);

        // r3 written in both E and M: newest wins
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd3, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        nop();
        @(negedge clk); chk_both("newest_fwdA", 0, 1); chk_both("newest_fwdB", 1, 0);

        // r0 never forwards
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk_both("r0_stall", 2, 0);
        nop();
        @(negedge clk); chk_both("r0_fwdA", 0, 0); chk_both("r0_fwdB", 1, 0);

        // LOAD r5 ; ADD r6 = r5 (decode held for the longest stall)
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_both("lu_stallF", 3, 1); chk_both("lu_stallD", 2, 1);
        chk_both("lu_flushE", 5, 1); chk_both("lu_flushD", 4, 0);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_c2_stall[u0]", stallD_o[0], 0); chk("lu_c2_stall[u1]", stallD_o[1], 1);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_fwdA[u0]", fwdA_o[0], 2); chk("lu_c3_stall[u1]", stallD_o[1], 1);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("lu_c4_stall[u1]", stallD_o[1], 0);
        nop(); nop();

        // load-use and taken branch in the same cycle
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk_both("br_flushD", 4, 1); chk_both("br_flushE", 5, 1);
        chk_both("br_stallF", 3, 0); chk_both("br_stallD", 2, 0);
        nop();
        @(negedge clk); chk_both("br_next_stall", 2, 0); chk_both("br_next_fwdA", 0, 0);

        // back-to-back branch pulses
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_both("bb1_flushD", 4, 1);
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk_both("bb2_flushD", 4, 1);
        nop();
        @(negedge clk); chk_both("bb3_flushD", 4, 0);

        // reset during the second of three stall cycles
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        step(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("rs_pre_stall[u1]", stallD_o[1], 1);
        #1 rst = 1'b0;
        #1;
        chk("rs_stallF[u1]", stallF_o[1], 0); chk("rs_stallD[u1]", stallD_o[1], 0);
        chk("rs_flushE[u1]", flushE_o[1], 0); chk("rs_fwdA[u1]", fwdA_o[1], 0);
        nop();
        @(posedge clk); #1 rst = 1'b1;
        step(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd3, 1'b1, 4'd4, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        nop();
        @(negedge clk); chk_both("post_rst_fwdA", 0, 1); chk_both("post_rst_fwdB", 1, 0);
        nop(); nop();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
